// File: rtl/regfile_pkg.sv
// Shared constants and state type for the register-file write-port scheduler.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    // $0 is hardwired to zero, so writes aimed at it are dropped.
    localparam int ZERO_REG = 0;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester grant logic for the register-file write port.
// Build option REGWR_ROUND_ROBIN_EN: defined gives two-way round-robin with a
// priority pointer; undefined gives fixed priority, A over B.
module rr_arb2 (
`ifdef REGWR_ROUND_ROBIN_EN
    input  logic clk_i,
    input  logic rst_i,
`endif
    input  logic en_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

`ifdef REGWR_ROUND_ROBIN_EN
    logic prio_b_q, prio_b_d;

    // Contested cycles go to whichever side the pointer favours.
    always_comb begin
        gnt_a_o = 1'b0;
        gnt_b_o = 1'b0;
        if (en_i) begin
            if (req_a_i && req_b_i) begin
                gnt_a_o = !prio_b_q;
                gnt_b_o = prio_b_q;
            end else begin
                gnt_a_o = req_a_i;
                gnt_b_o = req_b_i;
            end
        end
    end

    // Any grant, contested or not, hands priority to the other side.
    always_comb begin
        prio_b_d = prio_b_q;
        if (gnt_a_o) begin
            prio_b_d = 1'b1;
        end else if (gnt_b_o) begin
            prio_b_d = 1'b0;
        end
    end

    // Pointer register, starts favouring A.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_b_q <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
        end
    end
`else
    // A always wins; B only gets the port when A is idle.
    always_comb begin
        gnt_a_o = en_i && req_a_i;
        gnt_b_o = en_i && req_b_i && !req_a_i;
    end
`endif

endmodule

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the register file: clears every register after
// reset, then shares the single write port between requesters A and B.
// Build option REGWR_ROUND_ROBIN_EN selects round-robin arbitration
// (default: fixed priority, A over B).
module regfile_wr_sched #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              regWr,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic [DATA_W-1:0] WriteData,
    output logic              init_done
);
    import regfile_pkg::*;

    // One extra counter bit so NUM_REGS == 2**ADDR_W reaches the exit compare.
    localparam logic [ADDR_W:0]   CNT_LAST  = (ADDR_W+1)'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(ZERO_REG);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              regwr_q, regwr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              run;
    logic              gnt_a, gnt_b;

    assign run = (state_q == RUN);

    rr_arb2 u_arb (
`ifdef REGWR_ROUND_ROBIN_EN
        .clk_i   (CLK),
        .rst_i   (reset),
`endif
        .en_i    (run),
        .req_a_i (a_valid),
        .req_b_i (b_valid),
        .gnt_a_o (gnt_a),
        .gnt_b_o (gnt_b)
    );

    assign a_ready   = gnt_a;
    assign b_ready   = gnt_b;
    assign regWr     = regwr_q;
    assign WriteAddr = waddr_q;
    assign WriteData = wdata_q;
    assign init_done = run;

    // Next state: sweep zeros through the file, then forward granted writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regwr_d = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            INIT: begin
                regwr_d = 1'b1;
                waddr_d = cnt_q[ADDR_W-1:0];
                wdata_d = '0;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A write to $0 is accepted but never reaches the file.
                if (gnt_a && (a_addr != ADDR_ZERO)) begin
                    regwr_d = 1'b1;
                    waddr_d = a_addr;
                    wdata_d = a_data;
                end else if (gnt_b && (b_addr != ADDR_ZERO)) begin
                    regwr_d = 1'b1;
                    waddr_d = b_addr;
                    wdata_d = b_data;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // State, init counter and write-port output registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            regwr_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            regwr_q <= regwr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_regfile_wr_sched.sv
module tb_regfile_wr_sched;

`ifdef REGWR_ROUND_ROBIN_EN
    localparam bit ROUND_ROBIN = 1'b1;
`else
    localparam bit ROUND_ROBIN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        regWr;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic        init_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Register file as seen through the DUT write port.
    logic [31:0] shadow_rf [32];
    // Register file expected from the accepted requests.
    logic [31:0] exp_rf [32];
    // Round-robin model: whoever was granted last loses the next tie.
    bit mdl_prefer_b;

    regfile_wr_sched dut (
        .CLK       (CLK),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .regWr     (regWr),
        .WriteAddr (WriteAddr),
        .WriteData (WriteData),
        .init_done (init_done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (regWr) shadow_rf[WriteAddr] <= WriteData;
    end

    task automatic model_reset();
        mdl_prefer_b = 1'b0;
        for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
    endtask

    // Returns {grant_a, grant_b} for a RUN cycle.
    function automatic logic [1:0] model_grant(logic av, logic bv);
        if (av && bv) begin
            if (ROUND_ROBIN) return mdl_prefer_b ? 2'b01 : 2'b10;
            return 2'b10;
        end
        return {av, bv};
    endfunction

    task automatic model_accept(bit is_b, logic [4:0] addr, logic [31:0] data);
        mdl_prefer_b = !is_b;
        if (addr != 5'd0) exp_rf[addr] = data;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_init();
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (init_done) break;
        end
        n_checks++;
        if (init_done !== 1'b1) $display("FAIL wait_init: init_done=%b required 1 within 100 cycles", init_done);
        if (init_done !== 1'b1) n_fail++;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge CLK);
        n_checks++;
        if ({regWr, WriteAddr, WriteData, init_done, a_ready, b_ready} !== 41'h0) begin
            n_fail++;
            $display("FAIL reset_state: regWr=%b addr=%0d data=%h init_done=%b rdy=%b%b required all 0",
                     regWr, WriteAddr, WriteData, init_done, a_ready, b_ready);
        end
    endtask

    task automatic test_init_clear();
        for (int k = 0; k < 32; k++) begin
            @(negedge CLK);
            n_checks++;
            if (regWr !== 1'b1 || WriteAddr !== 5'(k) || WriteData !== 32'h0 ||
                init_done !== (k == 31)) begin
                n_fail++;
                $display("FAIL init_clear[%0d]: regWr=%b addr=%0d data=%h init_done=%b required 1/%0d/0/%b",
                         k, regWr, WriteAddr, WriteData, init_done, k, (k == 31));
            end
        end
        @(negedge CLK);
        n_checks++;
        if (regWr !== 1'b0 || init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL init_end: regWr=%b init_done=%b required 0/1", regWr, init_done);
        end
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (shadow_rf[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL init_cleared[%0d]: got %h required 0", i, shadow_rf[i]);
            end
        end
    endtask

    task automatic test_hold_during_init();
        int c;
        do_reset();
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h98765432;
        for (c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (a_ready === 1'b1) break;
        end
        n_checks++;
        if (c != 32 || init_done !== 1'b1 || regWr !== 1'b1 || WriteAddr !== 5'd31) begin
            n_fail++;
            $display("FAIL hold_init_ready: first a_ready at cycle %0d init_done=%b addr=%0d required cycle 32, 1, 31",
                     c, init_done, WriteAddr);
        end
        model_accept(1'b0, 5'd4, 32'h98765432);
        @(posedge CLK); #1;
        a_valid = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (regWr !== 1'b1 || WriteAddr !== 5'd4 || WriteData !== 32'h98765432) begin
            n_fail++;
            $display("FAIL hold_init_write: regWr=%b addr=%0d data=%h required 1/4/98765432",
                     regWr, WriteAddr, WriteData);
        end
    endtask

    task automatic test_contention();
        logic [1:0] expg;
        logic [1:0] prevg;
        do_reset();
        wait_init();
        prevg = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            a_valid = 1'b1; a_addr = 5'd1;  a_data = 32'h00ab3591;
            b_valid = 1'b1; b_addr = 5'd16; b_data = 32'h7632abcf;
            @(negedge CLK);
            expg = ROUND_ROBIN ? ((i % 2 == 1) ? 2'b01 : 2'b10) : 2'b10;
            n_checks++;
            if ({a_ready, b_ready} !== expg) begin
                n_fail++;
                $display("FAIL contention_grant[%0d]: ready=%b%b required %b", i, a_ready, b_ready, expg);
            end
            n_checks++;
            if (regWr !== (prevg != 2'b00) ||
                (prevg == 2'b10 && WriteAddr !== 5'd1) ||
                (prevg == 2'b01 && WriteAddr !== 5'd16)) begin
                n_fail++;
                $display("FAIL contention_write[%0d]: regWr=%b addr=%0d prev grant %b", i, regWr, WriteAddr, prevg);
            end
            if (expg[1]) model_accept(1'b0, 5'd1, 32'h00ab3591);
            else         model_accept(1'b1, 5'd16, 32'h7632abcf);
            prevg = expg;
        end
        @(posedge CLK); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (regWr !== 1'b1 || WriteAddr !== (prevg[1] ? 5'd1 : 5'd16) ||
            WriteData !== (prevg[1] ? 32'h00ab3591 : 32'h7632abcf)) begin
            n_fail++;
            $display("FAIL contention_last: regWr=%b addr=%0d data=%h", regWr, WriteAddr, WriteData);
        end
    endtask

    task automatic test_addr_zero();
        @(posedge CLK); #1;
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h1234fac9;
        @(negedge CLK);
        n_checks++;
        if (a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL addr_zero_ready: a_ready=%b required 1", a_ready);
        end
        model_accept(1'b0, 5'd0, 32'h1234fac9);
        @(posedge CLK); #1;
        a_valid = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (regWr !== 1'b0) begin
            n_fail++;
            $display("FAIL addr_zero_write: regWr=%b required 0", regWr);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge CLK); #1;
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'hcafe0004;
        @(negedge CLK);
        n_checks++;
        if (a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready0: a_ready=%b required 1", a_ready);
        end
        model_accept(1'b0, 5'd4, 32'hcafe0004);
        @(posedge CLK); #1;
        a_addr = 5'd16; a_data = 32'hbeef0016;
        @(negedge CLK);
        n_checks++;
        if (a_ready !== 1'b1 || regWr !== 1'b1 || WriteAddr !== 5'd4 || WriteData !== 32'hcafe0004) begin
            n_fail++;
            $display("FAIL b2b_first: rdy=%b regWr=%b addr=%0d data=%h required 1/1/4/cafe0004",
                     a_ready, regWr, WriteAddr, WriteData);
        end
        model_accept(1'b0, 5'd16, 32'hbeef0016);
        @(posedge CLK); #1;
        a_valid = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (regWr !== 1'b1 || WriteAddr !== 5'd16 || WriteData !== 32'hbeef0016) begin
            n_fail++;
            $display("FAIL b2b_second: regWr=%b addr=%0d data=%h required 1/16/beef0016",
                     regWr, WriteAddr, WriteData);
        end
        @(negedge CLK);
        n_checks++;
        if (regWr !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: regWr=%b required 0", regWr);
        end
    endtask

    task automatic test_reset_mid_run();
        @(posedge CLK); #1;
        reset = 1'b1;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h5a5a0009;
        @(posedge CLK); #1;
        reset = 1'b0;
        a_valid = 1'b0;
        model_reset();
        @(negedge CLK);
        n_checks++;
        if (regWr !== 1'b0 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: regWr=%b init_done=%b required 0/0", regWr, init_done);
        end
        @(negedge CLK);
        n_checks++;
        if (regWr !== 1'b1 || WriteAddr !== 5'd0 || WriteData !== 32'h0 || shadow_rf[9] === 32'h5a5a0009) begin
            n_fail++;
            $display("FAIL reset_restart: regWr=%b addr=%0d data=%h rf9=%h required 1/0/0 and no write to 9",
                     regWr, WriteAddr, WriteData, shadow_rf[9]);
        end
        wait_init();
        @(posedge CLK); #1;
        @(negedge CLK);
    endtask

    task automatic test_random(int n);
        logic       ap, bp, exp_wr;
        logic [1:0] g;
        logic [4:0] ea;
        logic [31:0] ed;
        ap = 1'b0; bp = 1'b0; exp_wr = 1'b0; ea = '0; ed = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            if (!ap && $urandom_range(1, 0) == 1) begin
                ap = 1'b1; a_addr = 5'($urandom_range(31, 0)); a_data = $urandom;
            end
            if (!bp && $urandom_range(1, 0) == 1) begin
                bp = 1'b1; b_addr = 5'($urandom_range(31, 0)); b_data = $urandom;
            end
            a_valid = ap; b_valid = bp;
            @(negedge CLK);
            g = model_grant(a_valid, b_valid);
            n_checks++;
            if ({a_ready, b_ready} !== g) begin
                n_fail++;
                $display("FAIL random_grant[%0d]: ready=%b%b required %b", i, a_ready, b_ready, g);
            end
            n_checks++;
            if (regWr !== exp_wr || (exp_wr && (WriteAddr !== ea || WriteData !== ed))) begin
                n_fail++;
                $display("FAIL random_write[%0d]: regWr=%b addr=%0d data=%h required %b/%0d/%h",
                         i, regWr, WriteAddr, WriteData, exp_wr, ea, ed);
            end
            exp_wr = 1'b0;
            if (g[1]) begin
                model_accept(1'b0, a_addr, a_data);
                exp_wr = (a_addr != 5'd0); ea = a_addr; ed = a_data; ap = 1'b0;
            end else if (g[0]) begin
                model_accept(1'b1, b_addr, b_data);
                exp_wr = (b_addr != 5'd0); ea = b_addr; ed = b_data; bp = 1'b0;
            end
        end
        @(posedge CLK); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (regWr !== exp_wr || (exp_wr && (WriteAddr !== ea || WriteData !== ed))) begin
            n_fail++;
            $display("FAIL random_write_last: regWr=%b addr=%0d data=%h required %b/%0d/%h",
                     regWr, WriteAddr, WriteData, exp_wr, ea, ed);
        end
        @(negedge CLK);
        for (int r = 0; r < 32; r++) begin
            n_checks++;
            if (shadow_rf[r] !== exp_rf[r]) begin
                n_fail++;
                $display("FAIL random_rf[%0d]: got %h required %h", r, shadow_rf[r], exp_rf[r]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) shadow_rf[i] = 32'hdeadbeef;
        model_reset();
        test_reset();
        test_init_clear();
        test_hold_during_init();
        test_contention();
        test_addr_zero();
        test_back_to_back();
        test_reset_mid_run();
        test_random(400);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wr_sched.md
# regfile_wr_sched

Write-port scheduler for the single-cycle CPU register file. It shares the file's single write port (regWr/WriteAddr/WriteData) between two writeback requesters, A and B, using valid/ready handshakes. After every reset it runs a clear sequence that writes zero to every register. It sits between the writeback sources and regFile, and its outputs connect directly to the regFile write inputs.

## Interface
Parameters:
- DATA_W, 32: register width
- ADDR_W, 5: register address width
- NUM_REGS, 32: registers cleared by the init sequence (≤ 2^ADDR_W)

Ports:
- CLK  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- a_valid  in  1  requester A has a write pending
- a_ready  out  1  A's write is accepted this cycle
- a_addr  in  ADDR_W  A's destination register
- a_data  in  DATA_W  A's write data
- b_valid, b_ready, b_addr, b_data: same as A, for requester B
- regWr  out  1  register file write enable (registered)
- WriteAddr  out  ADDR_W  register file write address (registered)
- WriteData  out  DATA_W  register file write data (registered)
- init_done  out  1  clear sequence complete; requests can be accepted

## Operation
- States: INIT, RUN. Reset forces INIT with cnt=0.
- INIT:
  - Each cycle, register regWr=1, WriteAddr=cnt, WriteData=0, then cnt++.
  - After registering the write to NUM_REGS-1, move to RUN and set init_done=1.
  - a_ready=b_ready=0 throughout INIT.
- RUN, grant logic:
  - The grant is combinational from a_valid, b_valid and the priority state.
  - At most one grant per cycle. x_ready=1 only for the granted requester, and only if that requester is valid.
  - A transfer happens when x_valid && x_ready.
- RUN, output register:
  - A transfer in cycle n registers regWr=1, WriteAddr=x_addr, WriteData=x_data, visible in cycle n+1.
  - With no transfer, regWr=0 and WriteAddr/WriteData hold their previous values.
- Address 0: a transfer is accepted (ready=1), but regWr stays 0. The write is discarded, since $0 is hardwired.
- Equal addresses from A and B are not merged. They are serialized by arbitration, and the later write wins in the file.
- Requesters must hold valid/addr/data stable until accepted. The block does not buffer unaccepted requests.
- RUN is terminal until the next reset.

## Timing
- Reset values: regWr=0, WriteAddr=0, WriteData=0, init_done=0, a_ready=0, b_ready=0, cnt=0, RR pointer=A.
- Init sequence:
  - The first edge after reset deasserts registers the write to address 0.
  - NUM_REGS edges later, init_done=1.
  - The first possible handshake is in the first RUN cycle. During that cycle regWr still shows the write to NUM_REGS-1.
- Write latency: handshake to regWr high is 1 cycle; the regFile captures it at the end of that cycle.
- Throughput: one write per cycle.
- Reset mid-operation: a handshake in the same cycle is dropped. The next cycle shows regWr=0 and init_done=0, and the clear sequence restarts from address 0.
- cnt width is ADDR_W+1, so NUM_REGS=2^ADDR_W does not wrap before the exit compare.

## Configuration
- Macro REGWR_ROUND_ROBIN_EN.
- Undefined: fixed priority, A over B. b_ready=1 only when !a_valid.
- Defined: two-way round-robin. After a grant to X, the other requester has priority on the next contested cycle. Uncontested grants also update the pointer. The pointer resets to A.

## Structure
- Shared package regfile_pkg: DATA_W, ADDR_W, NUM_REGS constants; state enum {INIT, RUN}; zero-register address constant.
- Sub-module rr_arb2: two-requester arbiter with its priority pointer, and the macro-selected fixed/round-robin behaviour. The top level holds the FSM, init counter and output registers.

## Test plan
- Reset pulse, no requests: for 32 cycles regWr=1 with WriteAddr 0..31 and WriteData=0. Then init_done=1 and regWr=0.
- a_valid held during INIT (a_addr=4, a_data=0x98765432): a_ready=0 until the first RUN cycle, then 1 for one cycle. The next cycle shows regWr=1, WriteAddr=4, WriteData=0x98765432.
- A (addr 1, 0x00ab3591) and B (addr 16, 0x7632abcf) both valid for 4 cycles:
  - Fixed priority: four A grants, b_ready=0.
  - Round-robin: grants A,B,A,B, and regWr outputs alternate addr 1/16.
- A writes addr 0 with 0x1234fac9: a_ready=1, and the next cycle regWr=0.
- reset asserted in a RUN cycle with a_valid=1: the next cycle shows regWr=0, init_done=0 and no write to a_addr. The clear sequence restarts at address 0.
- Back-to-back A writes to addr 4 then addr 16 (B idle): regWr=1 for two consecutive cycles, with matching addr/data each cycle.
